ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
- Parametrised PS/2 device-to-host receiver for keyboard/mouse input.
- Runs entirely on the system clock and oversamples the PS/2 clock and data lines; it does not clock on the PS/2 clock.
- Validates each frame (start, parity, stop), optionally folds E0/F0 prefix bytes into flags, and buffers codes in a FIFO behind a valid/ready interface for the downstream display/decode logic.

Parameters:
- DATA_W, 8: payload bits per frame, LSB first on the wire.
- FIFO_DEPTH, 4: output FIFO entries; power of 2, ≥2.
- SYNC_STAGES, 2: synchroniser flops on ps2_clk and ps2_data; ≥2.
- TIMEOUT_CYC, 5000: clk cycles without a PS/2 falling edge before a partial frame is aborted.
- DECODE_EN, 1: 1 = absorb E0/F0 prefixes into flags (DATA_W must be 8); 0 = every byte is pushed raw.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock line (asynchronous).
- ps2_data  in  1  raw PS/2 data line (asynchronous).
- code_ready  in  1  consumer accepts the head entry.
- code_valid  out  1  FIFO non-empty; head entry presented.
- code_data  out  DATA_W  head entry payload.
- code_ext  out  1  head entry was preceded by E0.
- code_brk  out  1  head entry was preceded by F0 (key release).
- frame_err  out  1  one-cycle pulse: frame rejected.
- err_code  out  2  cause, valid with frame_err: 01 parity, 10 stop bit, 11 timeout.
- overflow  out  1  one-cycle pulse: valid code dropped because FIFO full.
- fifo_count  out  clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0.
  - FSM to IDLE.
  - Shift register, bit counter, timeout counter, prefix flags and FIFO pointers cleared.
- Synchroniser flops reset to 1, the idle bus level.
- Edge detect: falling edge = previous synchronised ps2_clk 1, current 0; data is sampled from synchronised ps2_data in that same cycle E.
- FSM:
  - IDLE:
    - On an edge with data=0 (start bit): go to RECV, bit counter=0, timeout counter=0.
    - On an edge with data=1: ignore, stay IDLE.
  - RECV:
    - Each edge shifts one bit in and increments the counter: DATA_W data bits, then 1 parity bit, then 1 stop bit.
    - The edge carrying the stop bit moves to CHECK.
    - The timeout counter increments each cycle and clears on each edge.
    - At TIMEOUT_CYC-1: frame_err=1, err_code=11, go to IDLE, partial data discarded.
  - CHECK (one cycle, E+1):
    - Parity must be odd over data+parity bits, else err_code=01.
    - Stop bit must be 1, else err_code=10.
    - If both checks fail, report parity (01).
    - On error: frame_err pulses and nothing is pushed.
    - Always returns to IDLE.
- Prefix handling (DECODE_EN=1, good frame):
  - 0xE0 sets ext_pend; 0xF0 sets brk_pend. Neither is pushed.
  - Any other byte is pushed with {ext_pend, brk_pend} and both flags are cleared.
  - A frame error or timeout also clears both flags.
- FIFO:
  - Entry = {ext, brk, data}. Push is registered in CHECK, so code_valid/fifo_count reflect the entry at E+2.
  - Pop occurs when code_valid & code_ready. Outputs show the head combinationally from FIFO storage.
  - Full, push without pop: entry dropped, overflow pulses at E+1, prefix flags still cleared, count unchanged.
  - Full, push with simultaneous pop: both occur, no overflow, count stays FIFO_DEPTH.
  - Empty, push only: count→1. A pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Edges arriving while in CHECK are impossible at legal PS/2 rates (≥30 µs between edges) and are ignored.
- Reset asserted mid-frame aborts without any error pulse. After release, the block resynchronises on the next start bit; a stray trailing edge with data=1 is ignored. Stray data=0 bits are absorbed by the timeout.

Test Plan:
- Send 0x1C with odd parity=0, stop=1, code_ready=1 → code_valid for 1 cycle at E+2 with code_data=0x1C, ext=0, brk=0; frame_err stays 0.
- Send 0x1C with parity bit 1 → frame_err pulse with err_code=01; code_valid stays 0; fifo_count=0.
- DECODE_EN=1: send E0, F0, 75 → exactly one entry: data=0x75, ext=1, brk=1. A following 0x75 gives ext=0, brk=0.
- FIFO_DEPTH=4, code_ready=0: send 5 good frames 0x01..0x05 → fifo_count=4, one overflow pulse on the 5th. Then draining yields 0x01,0x02,0x03,0x04.
- Start bit plus 4 data edges, then idle → frame_err with err_code=11 after TIMEOUT_CYC cycles. The next full frame 0x2A is received correctly.
- FIFO full and code_ready=1 held during an arriving frame 0x33 → no overflow, count stays 4, 0x33 is read out last. Separately, pulse reset low mid-frame → all outputs 0 and the next frame is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with frame checking, optional
// E0/F0 prefix folding and an output FIFO behind a valid/ready handshake.
// Everything runs on clk; the PS/2 lines are oversampled, never used as clocks.
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   ps2_clk/data    raw asynchronous PS/2 lines
//   code_ready      consumer accepts the head entry
//   code_valid      FIFO non-empty; code_data/code_ext/code_brk show the head
//   frame_err       one-cycle pulse on a rejected frame, cause in err_code
//                   (01 parity, 10 stop bit, 11 timeout)
//   overflow        one-cycle pulse when a good code is dropped on a full FIFO
//   fifo_count      current FIFO occupancy
module ps2_rx_fifo #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 5000,
  parameter int unsigned DECODE_EN   = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  input  logic                            code_ready,
  output logic                            code_valid,
  output logic [DATA_W-1:0]               code_data,
  output logic                            code_ext,
  output logic                            code_brk,
  output logic                            frame_err,
  output logic [1:0]                      err_code,
  output logic                            overflow,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = DATA_W + 2;            // data + parity + stop
  localparam int unsigned EW = DATA_W + 2;            // {ext, brk, data}
  localparam int unsigned BW = $clog2(FW + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
  logic                 clk_prev_q;
  logic [FW-1:0]        sh_q, sh_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 ext_q, ext_d, brk_q, brk_d;
  logic                 frame_err_q, frame_err_d;
  logic [1:0]           err_code_q, err_code_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [EW-1:0]        mem_q [FIFO_DEPTH];

  logic clk_s, data_s, fall;
  logic push, pop, full, wr_en;
  logic [EW-1:0] push_entry, head;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];
  assign fall   = clk_prev_q & ~clk_s;

  // Synchronisers idle high, matching the released bus
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
      clk_prev_q  <= clk_s;
    end
  end

  // Frame FSM state and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      tmo_q       <= '0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      tmo_q       <= tmo_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
    end
  end

  // Next-state: bits shift in from the top so data lands LSB-first at bit 0
  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bit_cnt_d   = bit_cnt_q;
    tmo_d       = tmo_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    frame_err_d = 1'b0;
    err_code_d  = 2'b00;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall && !data_s) begin
          state_d   = RECV;
          bit_cnt_d = '0;
          tmo_d     = '0;
        end
      end
      RECV: begin
        if (fall) begin
          sh_d  = {data_s, sh_q[FW-1:1]};
          tmo_d = '0;
          if (bit_cnt_q == BW'(FW - 1)) state_d = CHECK;
          else bit_cnt_d = bit_cnt_q + BW'(1);
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'b11;
          ext_d       = 1'b0;
          brk_d       = 1'b0;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (!(^sh_q[DATA_W:0])) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'b01;
          ext_d       = 1'b0;
          brk_d       = 1'b0;
        end else if (!sh_q[FW-1]) begin
          frame_err_d = 1'b1;
          err_code_d  = 2'b10;
          ext_d       = 1'b0;
          brk_d       = 1'b0;
        end else if ((DECODE_EN != 0) && (sh_q[DATA_W-1:0] == DATA_W'(8'hE0))) begin
          ext_d = 1'b1;
        end else if ((DECODE_EN != 0) && (sh_q[DATA_W-1:0] == DATA_W'(8'hF0))) begin
          brk_d = 1'b1;
        end else begin
          push  = 1'b1;
          ext_d = 1'b0;
          brk_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FIFO control: a push into a full FIFO only lands if the head leaves this cycle
  assign push_entry = {ext_q, brk_q, sh_q[DATA_W-1:0]};
  assign full  = (count_q == CW'(FIFO_DEPTH));
  assign pop   = (count_q != '0) & code_ready;
  assign wr_en = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; the head is masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign code_valid = (count_q != '0);
  assign code_data  = head[DATA_W-1:0];
  assign code_brk   = head[DATA_W];
  assign code_ext   = head[DATA_W+1];
  assign fifo_count = count_q;
  assign frame_err  = frame_err_q;
  assign err_code   = err_code_q;
  assign overflow   = push & full & ~pop;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed plus randomized checks of ps2_rx_fifo against a queue-based
// model of the receiver's externally visible behaviour.
module tb_ps2_rx_fifo;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 400;
  localparam int unsigned HP    = 20;   // PS/2 half period in clk cycles

  logic clk = 1'b0;
  logic reset, ps2_clk, ps2_data, code_ready;
  logic code_valid, code_ext, code_brk, frame_err, overflow;
  logic [DW-1:0] code_data;
  logic [1:0] err_code;
  logic [$clog2(DEPTH):0] fifo_count;

  ps2_rx_fifo #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2),
                .TIMEOUT_CYC(TMO), .DECODE_EN(1)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code_ready(code_ready), .code_valid(code_valid), .code_data(code_data),
    .code_ext(code_ext), .code_brk(code_brk), .frame_err(frame_err),
    .err_code(err_code), .overflow(overflow), .fifo_count(fifo_count));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Observed activity
  logic [9:0] got[$];
  int err_seen = 0;
  int ovf_seen = 0;
  logic [1:0] last_err = 2'b00;

  always @(negedge clk) begin
    if (frame_err) begin
      err_seen++;
      last_err = err_code;
    end
    if (overflow) ovf_seen++;
    if (code_valid && code_ready) got.push_back({code_ext, code_brk, code_data});
  end

  // Reference model
  logic [9:0] mq[$];
  logic [9:0] exp_q[$];
  logic m_ext = 1'b0, m_brk = 1'b0;
  int exp_err = 0;
  int exp_ovf = 0;
  logic [1:0] exp_last = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit perr, input bit serr, input bit same_pop);
    logic [9:0] e;
    if (perr || serr) begin
      exp_err++;
      exp_last = perr ? 2'b01 : 2'b10;
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (d == 8'hE0) begin
      m_ext = 1'b1;
    end else if (d == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      e = {m_ext, m_brk, d};
      m_ext = 1'b0; m_brk = 1'b0;
      if (same_pop && mq.size() > 0) begin
        exp_q.push_back(mq.pop_front());
        mq.push_back(e);
      end else if (mq.size() < DEPTH) mq.push_back(e);
      else exp_ovf++;
    end
  endtask

  // Drive one PS/2 frame; 'win' raises code_ready only for the cycle in
  // which the DUT evaluates the stop bit (3 clk after the falling edge)
  task automatic rx(input logic [7:0] d, input bit perr, input bit serr, input bit win);
    logic [10:0] b;
    b = {~serr, (~^d) ^ perr, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = b[i];
      wait_cyc(HP);
      ps2_clk = 1'b0;
      if (win && i == 10) begin
        wait_cyc(3);
        code_ready = 1'b1;
        wait_cyc(1);
        code_ready = 1'b0;
        wait_cyc(HP - 4);
      end else wait_cyc(HP);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_cyc(HP);
    model_frame(d, perr, serr, win);
  endtask

  task automatic send_bits(input logic [10:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = b[i];
      wait_cyc(HP);
      ps2_clk = 1'b0;
      wait_cyc(HP);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic drain();
    code_ready = 1'b1;
    wait_cyc(DEPTH + 4);
    while (mq.size() > 0) exp_q.push_back(mq.pop_front());
  endtask

  task automatic cmp_logs(input string tag);
    chk({tag, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_entry%0d", tag, i), got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, code_valid, 0);
    chk({tag, "_data"}, code_data, 0);
    chk({tag, "_ext"}, code_ext, 0);
    chk({tag, "_brk"}, code_brk, 0);
    chk({tag, "_ferr"}, frame_err, 0);
    chk({tag, "_ecode"}, err_code, 0);
    chk({tag, "_ovf"}, overflow, 0);
    chk({tag, "_count"}, fifo_count, 0);
  endtask

  initial begin
    logic [7:0] d;
    bit pe, se;
    reset = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; code_ready = 1'b0;
    wait_cyc(3);
    chk_idle_outputs("reset");
    reset = 1'b1;
    wait_cyc(3);

    // Single good frame, consumer always ready
    code_ready = 1'b1;
    rx(8'h1C, 0, 0, 0);
    drain();
    cmp_logs("good1c");
    chk("good1c_err", err_seen, exp_err);

    // Parity error
    rx(8'h1C, 1, 0, 0);
    chk("par_err_cnt", err_seen, exp_err);
    chk("par_err_code", last_err, exp_last);
    chk("par_count", fifo_count, 0);
    drain();
    cmp_logs("par");

    // Prefix folding
    rx(8'hE0, 0, 0, 0);
    rx(8'hF0, 0, 0, 0);
    rx(8'h75, 0, 0, 0);
    rx(8'h75, 0, 0, 0);
    drain();
    cmp_logs("prefix");

    // Overflow on the fifth frame, then drain in order
    code_ready = 1'b0;
    for (int i = 1; i <= 5; i++) rx(8'(i), 0, 0, 0);
    chk("ovf_count", fifo_count, mq.size());
    chk("ovf_pulses", ovf_seen, exp_ovf);
    drain();
    cmp_logs("ovf_drain");

    // Timeout on a partial frame, then recovery
    send_bits(11'b000_0001_1010, 5);
    wait_cyc(TMO + 50);
    exp_err++; exp_last = 2'b11; m_ext = 1'b0; m_brk = 1'b0;
    chk("tmo_err_cnt", err_seen, exp_err);
    chk("tmo_err_code", last_err, exp_last);
    rx(8'h2A, 0, 0, 0);
    drain();
    cmp_logs("tmo_recover");

    // Full FIFO with a pop in the same cycle as the push
    code_ready = 1'b0;
    for (int i = 0; i < 4; i++) rx(8'h10 + 8'(i), 0, 0, 0);
    rx(8'h33, 0, 0, 1);
    chk("samepop_count", fifo_count, mq.size());
    chk("samepop_ovf", ovf_seen, exp_ovf);
    drain();
    cmp_logs("samepop");

    // Stop-bit error, and both errors reporting parity
    rx(8'h5A, 0, 1, 0);
    chk("stop_err_code", last_err, exp_last);
    rx(8'h5A, 1, 1, 0);
    chk("both_err_code", last_err, exp_last);
    chk("errs_so_far", err_seen, exp_err);

    // Randomized frames including prefixes and injected errors
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 7))
        0: d = 8'hE0;
        1: d = 8'hF0;
        default: d = 8'($urandom_range(0, 255));
      endcase
      pe = ($urandom_range(0, 5) == 0);
      se = ($urandom_range(0, 5) == 0);
      rx(d, pe, se, 0);
      drain();
    end
    chk("rand_count", fifo_count, 0);
    chk("rand_err_cnt", err_seen, exp_err);
    chk("rand_ovf", ovf_seen, exp_ovf);
    cmp_logs("rand");

    // Reset mid-frame with a buffered entry
    code_ready = 1'b0;
    rx(8'h44, 0, 0, 0);
    chk("pre_rst_count", fifo_count, 1);
    send_bits(11'b000_0011_0110, 5);
    reset = 1'b0;
    wait_cyc(2);
    chk_idle_outputs("midrst");
    mq.delete(); m_ext = 1'b0; m_brk = 1'b0;
    reset = 1'b1;
    wait_cyc(3);
    code_ready = 1'b1;
    send_bits(11'b000_0000_0001, 1);
    rx(8'h6B, 0, 0, 0);
    drain();
    cmp_logs("post_rst");
    chk("final_err_cnt", err_seen, exp_err);
    chk("final_ovf", ovf_seen, exp_ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
